// File: rtl/ysyx_22041071_axi_r_slave_pkg.sv
// Shared AXI widths, burst/response encodings, FSM state codes and the
// response-FIFO entry type for the AXI read-channel responder.
package ysyx_22041071_axi_r_slave_pkg;

  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 64;
  localparam int AXI_DATA_W  = 64;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;
  localparam int AXI_USER_W  = 1;

  localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] READ_IDLE = 1'b0;
  localparam logic [0:0] READ_DATA = 1'b1;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_RESP_W-1:0] resp;
    logic                  last;
  } rsp_t;

  // WRAP bursts are only meaningful for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/ysyx_22041071_axi_r_slave_if.sv
// AXI4 read address / read data channel bundle.
interface ysyx_22041071_axi_r_slave_if;
  import ysyx_22041071_axi_r_slave_pkg::*;

  logic                   axi_ar_valid_i;
  logic                   axi_ar_ready_o;
  logic [AXI_ID_W-1:0]    axi_ar_id_i;
  logic [AXI_ADDR_W-1:0]  axi_ar_addr_i;
  logic [AXI_LEN_W-1:0]   axi_ar_len_i;
  logic [AXI_SIZE_W-1:0]  axi_ar_size_i;
  logic [AXI_BURST_W-1:0] axi_ar_burst_i;

  logic                   axi_r_valid_o;
  logic                   axi_r_ready_i;
  logic [AXI_DATA_W-1:0]  axi_r_data_o;
  logic [AXI_RESP_W-1:0]  axi_r_resp_o;
  logic                   axi_r_last_o;
  logic [AXI_ID_W-1:0]    axi_r_id_o;
  logic [AXI_USER_W-1:0]  axi_r_user_o;

  modport slave (
    input  axi_ar_valid_i, axi_ar_id_i, axi_ar_addr_i, axi_ar_len_i,
           axi_ar_size_i, axi_ar_burst_i, axi_r_ready_i,
    output axi_ar_ready_o, axi_r_valid_o, axi_r_data_o, axi_r_resp_o,
           axi_r_last_o, axi_r_id_o, axi_r_user_o
  );

  modport master (
    output axi_ar_valid_i, axi_ar_id_i, axi_ar_addr_i, axi_ar_len_i,
           axi_ar_size_i, axi_ar_burst_i, axi_r_ready_i,
    input  axi_ar_ready_o, axi_r_valid_o, axi_r_data_o, axi_r_resp_o,
           axi_r_last_o, axi_r_id_o, axi_r_user_o
  );

endinterface

// File: rtl/ysyx_22041071_axi_rsp_fifo.sv
// Two-entry synchronous FIFO holding {data, resp, last} R-channel beats.
module ysyx_22041071_axi_rsp_fifo
  import ysyx_22041071_axi_r_slave_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  rsp_t       i_push_data,
  input  logic       i_pop,
  output rsp_t       o_head,
  output logic [1:0] o_count,
  output logic       o_empty,
  output logic       o_full
);

  rsp_t       r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;

  // Storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'd2);

endmodule

// File: rtl/ysyx_22041071_axi_r_slave.sv
// AXI4 read-channel responder in front of a 1-cycle-latency SRAM read port.
// One burst outstanding; INCR/FIXED/WRAP; out-of-range and illegal bursts
// return SLVERR beats without touching the SRAM.
//
// state     | meaning
// READ_IDLE | ar_ready high, waiting for an AR handshake
// READ_DATA | issuing SRAM reads and returning R beats; one bubble after last
module ysyx_22041071_axi_r_slave
  import ysyx_22041071_axi_r_slave_pkg::*;
#(
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter int          MEM_AW   = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  ysyx_22041071_axi_r_slave_if.slave      axi,
  output logic                            mem_en_o,
  output logic [MEM_AW-1:0]               mem_addr_o,
  input  logic [AXI_DATA_W-1:0]           mem_rdata_i
);

  logic [0:0]             r_state;
  logic                   r_done;
  logic [AXI_ID_W-1:0]    r_id;
  logic [AXI_ADDR_W-1:0]  r_addr;
  logic [AXI_LEN_W-1:0]   r_len;
  logic [AXI_SIZE_W-1:0]  r_size;
  logic [AXI_BURST_W-1:0] r_burst;
  logic [AXI_LEN_W:0]     r_issue_cnt;
  logic                   r_inflight;
  logic                   r_pend_err;
  logic                   r_pend_last;

  logic [AXI_ADDR_W-1:0]  w_step;
  logic [AXI_ADDR_W-1:0]  w_wrap_mask;
  logic [AXI_ADDR_W-1:0]  w_next_addr;
  logic [AXI_ADDR_W-1:0]  w_off;
  logic                   w_in_range;
  logic                   w_bad_burst;
  logic                   w_err;
  logic                   w_ar_hs;
  logic                   w_r_hs;
  logic                   w_r_valid;
  logic [2:0]             w_occ;
  logic                   w_issue;
  logic                   w_fifo_push;
  logic                   w_fifo_pop;
  logic [1:0]             w_fifo_count;
  logic                   w_fifo_empty;
  logic                   w_fifo_full;
  rsp_t                   w_push_word;
  rsp_t                   w_fifo_head;
  rsp_t                   w_head;

  assign w_step      = 64'd1 << r_size;
  assign w_wrap_mask = ((64'(r_len) + 64'd1) << r_size) - 64'd1;
  assign w_off       = r_addr - MEM_BASE;
  assign w_in_range  = (r_addr >= MEM_BASE) && ((w_off >> (MEM_AW + 3)) == 64'd0);
  assign w_bad_burst = (r_burst == 2'b11) || (r_size > 3'd3) ||
                       ((r_burst == BURST_WRAP) && !wrap_len_ok(r_len));
  assign w_err       = !w_in_range || w_bad_burst;

  // Address of the following beat; the current one lives in r_addr.
  always_comb begin
    w_next_addr = r_addr + w_step;
    case (r_burst)
      BURST_FIXED: w_next_addr = r_addr;
      BURST_WRAP:  w_next_addr = (r_addr & ~w_wrap_mask) | ((r_addr + w_step) & w_wrap_mask);
      default:     w_next_addr = r_addr + w_step;
    endcase
  end

  assign w_ar_hs = axi.axi_ar_valid_i && axi.axi_ar_ready_o;
  assign w_r_hs  = w_r_valid && axi.axi_r_ready_i;

  // Slots in use = stored beats + beat landing next edge - beat leaving now.
  assign w_occ   = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_r_hs};
  assign w_issue = !reset && (r_state == READ_DATA) && !r_done &&
                   (r_issue_cnt <= {1'b0, r_len}) && (w_occ < 3'd2);

  assign mem_en_o   = w_issue && !w_err;
  assign mem_addr_o = w_off[MEM_AW+2:3];

  assign w_push_word.data = r_pend_err ? '0 : mem_rdata_i;
  assign w_push_word.resp = r_pend_err ? RESP_SLVERR : RESP_OKAY;
  assign w_push_word.last = r_pend_last;

  // An empty FIFO passes the landing beat straight through so the first
  // beat is visible in the same cycle the SRAM returns it.
  assign w_head      = w_fifo_empty ? w_push_word : w_fifo_head;
  assign w_r_valid   = !reset && (!w_fifo_empty || r_inflight);
  assign w_fifo_pop  = w_r_hs && !w_fifo_empty;
  assign w_fifo_push = r_inflight && !(w_fifo_empty && w_r_hs) && !w_fifo_full;

  ysyx_22041071_axi_rsp_fifo u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_fifo_push),
    .i_push_data (w_push_word),
    .i_pop       (w_fifo_pop),
    .o_head      (w_fifo_head),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full)
  );

  assign axi.axi_ar_ready_o = !reset && (r_state == READ_IDLE);
  assign axi.axi_r_valid_o  = w_r_valid;
  assign axi.axi_r_data_o   = w_r_valid ? w_head.data : '0;
  assign axi.axi_r_resp_o   = w_r_valid ? w_head.resp : '0;
  assign axi.axi_r_last_o   = w_r_valid ? w_head.last : 1'b0;
  assign axi.axi_r_id_o     = r_id;
  assign axi.axi_r_user_o   = '0;

  // Burst FSM, address walker and one-cycle SRAM read pipeline tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= READ_IDLE;
      r_done      <= 1'b0;
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_issue_cnt <= '0;
      r_inflight  <= 1'b0;
      r_pend_err  <= 1'b0;
      r_pend_last <= 1'b0;
    end else begin
      r_inflight  <= w_issue;
      r_pend_err  <= w_issue && w_err;
      r_pend_last <= w_issue && (r_issue_cnt == {1'b0, r_len});
      case (r_state)
        READ_IDLE: begin
          if (w_ar_hs) begin
            r_id        <= axi.axi_ar_id_i;
            r_addr      <= axi.axi_ar_addr_i & ~((64'd1 << axi.axi_ar_size_i) - 64'd1);
            r_len       <= axi.axi_ar_len_i;
            r_size      <= axi.axi_ar_size_i;
            r_burst     <= axi.axi_ar_burst_i;
            r_issue_cnt <= '0;
            r_done      <= 1'b0;
            r_state     <= READ_DATA;
          end
        end
        default: begin
          if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + 9'd1;
            r_addr      <= w_next_addr;
          end
          if (w_r_hs && axi.axi_r_last_o) begin
            r_done <= 1'b1;
          end
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= READ_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/ysyx_22041071_axi_r_slave.md
Name: ysyx_22041071_axi_r_slave

Overview:
AXI4 read-channel responder (AR accept, R return) in front of a synchronous single-port SRAM read port with 1-cycle latency. It serves the core's AXI read master in simulation and SoC memory models. It handles INCR, FIXED and WRAP bursts, R-channel backpressure with no data loss, and out-of-range and illegal-burst error responses. It supports one outstanding burst at a time.

Parameters:
MEM_BASE, 64'h8000_0000, byte base address of the backing memory
MEM_AW, 16, SRAM word-index width; the memory holds 2^MEM_AW 64-bit words

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
axi_ar_valid_i  in  1  AR valid
axi_ar_ready_o  out  1  AR ready
axi_ar_id_i  in  4  transaction ID
axi_ar_addr_i  in  64  start byte address
axi_ar_len_i  in  8  beats minus 1
axi_ar_size_i  in  3  bytes per beat = 2^size; legal range 0..3
axi_ar_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
axi_r_valid_o  out  1  R valid
axi_r_ready_i  in  1  R ready
axi_r_data_o  out  64  full aligned 64-bit word; the master selects the byte lanes
axi_r_resp_o  out  2  00 OKAY, 10 SLVERR
axi_r_last_o  out  1  final beat of the burst
axi_r_id_o  out  4  ID echoed from AR
axi_r_user_o  out  1  constant 0
mem_en_o  out  1  SRAM read enable
mem_addr_o  out  MEM_AW  SRAM word index
mem_rdata_i  in  64  SRAM data, valid the cycle after mem_en_o

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state IDLE, FIFO empty, no read in flight.
  - axi_ar_ready_o=0 while reset is high.
  - axi_r_valid_o=0, axi_r_last_o=0, axi_r_resp_o=0, axi_r_id_o=0, axi_r_data_o=0, mem_en_o=0.
- State IDLE:
  - axi_ar_ready_o=1.
  - On an AR handshake, latch id, addr, len, size and burst; clear issue_cnt and beat_cnt; go to BURST.
- State BURST:
  - axi_ar_ready_o=0.
  - Return to IDLE in the cycle after the R handshake with r_last=1. This gives one bubble between bursts.
- Issue rule: mem_en_o=1 in a cycle when issue_cnt ≤ len and (fifo_count + inflight − r_hs) < 2.
  - inflight = mem_en_o registered one cycle.
  - The FIFO therefore never overflows.
- Beat address i:
  - INCR: A0 + i·2^size, where A0 = addr aligned down to 2^size.
  - FIXED: A0 for every beat.
  - WRAP: the wrap boundary is 2^size·(len+1). The address wraps inside the block containing A0.
  - mem_addr_o = ((beat_addr − MEM_BASE) >> 3)[MEM_AW−1:0].
- Error beats:
  - Condition: the beat address is outside [MEM_BASE, MEM_BASE + 2^(MEM_AW+3)), or burst=11, or size>3.
  - Effect: mem_en_o stays 0, but the slot is still allocated. One cycle later, push data 0 with resp=10.
  - WRAP with len not in {1,3,7,15}: every beat returns SLVERR.
- FIFO entries hold {data, resp, last}.
  - last = (beat index == len).
  - axi_r_valid_o = FIFO not empty; R outputs come from the FIFO head.
  - axi_r_id_o holds the latched ID for the whole burst.
- Latency: AR handshake in cycle T → first mem_en_o in T+1 → axi_r_valid_o=1 in T+2.
  - With r_ready held high: one beat per cycle.
- Backpressure: R outputs stay stable while axi_r_valid_o=1 and axi_r_ready_i=0, per AXI.
  - Issue stalls once 2 slots are occupied and resumes in the same cycle a pop frees a slot.
- Push and pop in the same cycle: both happen and fifo_count is unchanged.
- Reset mid-burst: the burst is abandoned. All state returns to reset values in the next cycle. mem_rdata_i arriving after reset is ignored.

Decomposition:
- Shared package/define file holds:
  - AXI width macros: ID, ADDR, DATA, LEN, SIZE, BURST, RESP, USER.
  - Burst encodings FIXED/INCR/WRAP.
  - Resp encodings OKAY/SLVERR.
  - State encodings READ_IDLE/READ_DATA.
- Sub-module ysyx_22041071_axi_rsp_fifo: 2-entry synchronous FIFO, {data, resp, last} wide, with push/pop/count/empty/full outputs.
- The address generator and issue logic stay in the top module.

Test Plan:
- Single beat: addr=0x8000_0010, len=0, size=3, INCR, id=5, r_ready=1 → r_valid in T+2; data = mem[2]; resp=00; last=1; id=5; ar_ready high again 2 cycles after the R handshake.
- INCR burst: addr=0x8000_0000, len=3, size=3, r_ready=1 → 4 consecutive beats mem[0..3]; last only on beat 3.
- Backpressure: same 4-beat burst, r_ready low for 5 cycles after the first r_valid → beat 0 held stable; at most 2 mem_en_o pulses before the first pop; data order preserved with no loss or duplication.
- WRAP: addr=0x8000_0018, len=3, size=3 → word indices 3, 0, 1, 2.
- FIXED: len=2 → mem[k] returned 3 times.
- Errors:
  - addr=0x1000, len=1 → two beats, resp=10, data=0, mem_en_o never asserted, last on beat 1.
  - burst=11 → SLVERR on every beat.
- Reset mid-burst: assert reset during beat 1 of a len=7 burst → next cycle r_valid=0 and ar_ready=1; a following single-beat read returns correct data.
